// File: rtl/bcd_display_mux.sv
// bcd_display_mux: latches a packed BCD value plus decimal points and scans it
// out onto a multiplexed, active-low 7-segment display. Every digit slot
// starts with a short all-off window to suppress ghosting. Frame_o marks the
// first output cycle of digit 0's slot after each scan wrap.
// Optional build macro: LEADING_ZERO_BLANK_EN turns off the segments of
// leading zero digits (digit 0 is always shown).
module bcd_display_mux #(
    parameter int DIGITS      = 3,
    parameter int DIGIT_TICKS = 1000,
    parameter int BLANK_TICKS = 50
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Load_i,
    input  logic [DIGITS*4-1:0]   BCD_i,
    input  logic [DIGITS-1:0]     DecimalPoints_i,
    output logic [7:0]            Segments_o,
    output logic [DIGITS-1:0]     Digits_o,
    output logic                  Frame_o
);

    localparam int CNT_W = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_TICKS);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    // Segment bits {g,f,e,d,c,b,a}, active-low; anything above 9 shows a dash.
    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'd0:    g = 7'h40;
            4'd1:    g = 7'h79;
            4'd2:    g = 7'h24;
            4'd3:    g = 7'h30;
            4'd4:    g = 7'h19;
            4'd5:    g = 7'h12;
            4'd6:    g = 7'h02;
            4'd7:    g = 7'h78;
            4'd8:    g = 7'h00;
            4'd9:    g = 7'h10;
            default: g = 7'h3F;
        endcase
        return g;
    endfunction

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DIGITS*4-1:0] bcd_q;
    logic [DIGITS-1:0]   dp_q;
    logic                valid_q;
    logic                wrap_q, wrap_d;
    logic                frame_q;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   dig_q, dig_d;
    logic [DIGITS-1:0]   lead_zero;

    // Slot tick counter and digit index; wrap_d flags the last tick of the scan.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        idx_d  = idx_q;
        wrap_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d  = '0;
                wrap_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit above 0 is a leading zero when it and every higher digit carry
    // a zero nibble and no decimal point.
    always_comb begin
        logic run;
        lead_zero = '0;
        run       = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run          = run && (bcd_q[k*4 +: 4] == 4'd0) && !dp_q[k];
            lead_zero[k] = run;
        end
    end
`else
    assign lead_zero = '0;
`endif

    // Output decode from the current scan position and latched data.
    always_comb begin
        logic [3:0]        nib;
        logic              dpb;
        logic              lzb;
        logic              blank;
        logic [DIGITS-1:0] dig_sel;
        nib     = '0;
        dpb     = 1'b0;
        lzb     = 1'b0;
        dig_sel = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib        = bcd_q[k*4 +: 4];
                dpb        = dp_q[k];
                lzb        = lead_zero[k];
                dig_sel[k] = 1'b0;
            end
        end
        blank = !valid_q || (cnt_q < CNT_BLANK);
        seg_d = (blank || lzb) ? 8'hFF : {~dpb, glyph(nib)};
        dig_d = blank ? '1 : dig_sel;
    end

    // State and registered outputs; a load never disturbs the scan phase.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            bcd_q   <= '0;
            dp_q    <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            frame_q <= 1'b0;
            seg_q   <= 8'hFF;
            dig_q   <= '1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            frame_q <= wrap_q;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
            if (Load_i) begin
                bcd_q   <= BCD_i;
                dp_q    <= DecimalPoints_i;
                valid_q <= 1'b1;
            end
        end
    end

    assign Segments_o = seg_q;
    assign Digits_o   = dig_q;
    assign Frame_o    = frame_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Directed bench for bcd_display_mux with DIGITS=3, DIGIT_TICKS=4,
// BLANK_TICKS=1. Expected values follow the build macro LEADING_ZERO_BLANK_EN.
module tb_bcd_display_mux;

    localparam int DIGITS      = 3;
    localparam int DIGIT_TICKS = 4;
    localparam int BLANK_TICKS = 1;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Load_i;
    logic [11:0] BCD_i;
    logic [2:0]  DecimalPoints_i;
    logic [7:0]  Segments_o;
    logic [2:0]  Digits_o;
    logic        Frame_o;

    int checks   = 0;
    int failures = 0;
    int n        = 0;   // rising edges since reset release

    bcd_display_mux #(
        .DIGITS(DIGITS),
        .DIGIT_TICKS(DIGIT_TICKS),
        .BLANK_TICKS(BLANK_TICKS)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Load_i(Load_i),
        .BCD_i(BCD_i),
        .DecimalPoints_i(DecimalPoints_i),
        .Segments_o(Segments_o),
        .Digits_o(Digits_o),
        .Frame_o(Frame_o)
    );

    always #5 Clock = ~Clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] dsel(input int idx);
        logic [2:0] d;
        d      = 3'b111;
        d[idx] = 1'b0;
        return d;
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
        n++;
    endtask

    task automatic do_reset();
        Reset  = 1'b0;
        Load_i = 1'b0;
        step();
        step();
        Reset = 1'b1;
        n     = 0;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Load_i = 1'b0; BCD_i = '0; DecimalPoints_i = '0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({Digits_o, Segments_o, Frame_o} !== {3'b111, 8'hFF, 1'b0}) begin
                failures++;
                $display("FAIL reset_active: got dig=%b seg=%h frame=%b want 111/ff/0",
                         Digits_o, Segments_o, Frame_o);
            end
        end
        Reset = 1'b1;
        n     = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            checks++;
            if ({Digits_o, Segments_o} !== {3'b111, 8'hFF}) begin
                failures++;
                $display("FAIL reset_idle n=%0d: got dig=%b seg=%h want 111/ff",
                         n, Digits_o, Segments_o);
            end
            checks++;
            if (Frame_o !== ((n == 13) || (n == 25))) begin
                failures++;
                $display("FAIL reset_frame n=%0d: got %b want %b",
                         n, Frame_o, ((n == 13) || (n == 25)));
            end
        end
    endtask

    task automatic test_scan_127();
        logic [7:0] tab [3];
        int pos;
        tab[0] = 8'hF8; tab[1] = 8'hA4; tab[2] = 8'hF9;
        do_reset();
        BCD_i = 12'h127; DecimalPoints_i = 3'b000; Load_i = 1'b1;
        step();
        Load_i = 1'b0;
        checks++;
        if ({Digits_o, Segments_o} !== {3'b111, 8'hFF}) begin
            failures++;
            $display("FAIL scan_preload: got dig=%b seg=%h want 111/ff", Digits_o, Segments_o);
        end
        for (int i = 0; i < 24; i++) begin
            step();
            pos = (n - 1) % 12;
            checks++;
            if ((pos % 4) == 0) begin
                if ({Digits_o, Segments_o} !== {3'b111, 8'hFF}) begin
                    failures++;
                    $display("FAIL scan_blank n=%0d: got dig=%b seg=%h want 111/ff",
                             n, Digits_o, Segments_o);
                end
            end else if ({Digits_o, Segments_o} !== {dsel(pos / 4), tab[pos / 4]}) begin
                failures++;
                $display("FAIL scan_127 n=%0d: got dig=%b seg=%h want %b/%h",
                         n, Digits_o, Segments_o, dsel(pos / 4), tab[pos / 4]);
            end
            checks++;
            if (Frame_o !== ((n == 13) || (n == 25))) begin
                failures++;
                $display("FAIL scan_frame n=%0d: got %b want %b",
                         n, Frame_o, ((n == 13) || (n == 25)));
            end
        end
    endtask

    task automatic test_leading_zero();
        logic [7:0] tab [3];
        int pos;
        tab[0] = 8'hF8;
        tab[1] = LZB ? 8'hFF : 8'hC0;
        tab[2] = LZB ? 8'hFF : 8'hC0;
        do_reset();
        BCD_i = 12'h007; DecimalPoints_i = 3'b000; Load_i = 1'b1;
        step();
        Load_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            pos = (n - 1) % 12;
            if ((pos % 4) != 0) begin
                checks++;
                if ({Digits_o, Segments_o} !== {dsel(pos / 4), tab[pos / 4]}) begin
                    failures++;
                    $display("FAIL lzb_007 n=%0d: got dig=%b seg=%h want %b/%h",
                             n, Digits_o, Segments_o, dsel(pos / 4), tab[pos / 4]);
                end
            end
        end
    endtask

    task automatic test_decimal_point();
        logic [7:0] tab [3];
        int pos;
        tab[0] = 8'h92;
        tab[1] = 8'h40;
        tab[2] = LZB ? 8'hFF : 8'hC0;
        do_reset();
        BCD_i = 12'h005; DecimalPoints_i = 3'b010; Load_i = 1'b1;
        step();
        Load_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            pos = (n - 1) % 12;
            if ((pos % 4) != 0) begin
                checks++;
                if ({Digits_o, Segments_o} !== {dsel(pos / 4), tab[pos / 4]}) begin
                    failures++;
                    $display("FAIL dp_005 n=%0d: got dig=%b seg=%h want %b/%h",
                             n, Digits_o, Segments_o, dsel(pos / 4), tab[pos / 4]);
                end
            end
        end
    endtask

    task automatic test_dash_reload();
        logic [7:0] old_tab [3];
        logic [7:0] new_tab [3];
        int pos;
        old_tab[0] = 8'h90; old_tab[1] = 8'hBF; old_tab[2] = LZB ? 8'hFF : 8'hC0;
        new_tab[0] = 8'hF9; new_tab[1] = 8'hA4; new_tab[2] = 8'hB0;
        do_reset();
        BCD_i = 12'h0A9; DecimalPoints_i = 3'b000; Load_i = 1'b1;
        step();
        Load_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            pos = (n - 1) % 12;
            if ((pos % 4) != 0) begin
                checks++;
                if ({Digits_o, Segments_o} !== {dsel(pos / 4), old_tab[pos / 4]}) begin
                    failures++;
                    $display("FAIL dash_0a9 n=%0d: got dig=%b seg=%h want %b/%h",
                             n, Digits_o, Segments_o, dsel(pos / 4), old_tab[pos / 4]);
                end
            end
        end
        // Reload in the middle of digit 1's slot.
        BCD_i = 12'h321; Load_i = 1'b1;
        step();
        Load_i = 1'b0;
        checks++;
        if ({Digits_o, Segments_o} !== {3'b101, 8'hBF}) begin
            failures++;
            $display("FAIL reload_edge: got dig=%b seg=%h want 101/bf", Digits_o, Segments_o);
        end
        step();
        checks++;
        if ({Digits_o, Segments_o} !== {3'b101, 8'hA4}) begin
            failures++;
            $display("FAIL reload_next: got dig=%b seg=%h want 101/a4", Digits_o, Segments_o);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            pos = (n - 1) % 12;
            checks++;
            if ((pos % 4) == 0) begin
                if ({Digits_o, Segments_o} !== {3'b111, 8'hFF}) begin
                    failures++;
                    $display("FAIL reload_blank n=%0d: got dig=%b seg=%h want 111/ff",
                             n, Digits_o, Segments_o);
                end
            end else if ({Digits_o, Segments_o} !== {dsel(pos / 4), new_tab[pos / 4]}) begin
                failures++;
                $display("FAIL reload_321 n=%0d: got dig=%b seg=%h want %b/%h",
                         n, Digits_o, Segments_o, dsel(pos / 4), new_tab[pos / 4]);
            end
        end
        checks++;
        if (Frame_o !== 1'b1) begin
            failures++;
            $display("FAIL reload_frame n=%0d: got %b want 1", n, Frame_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        BCD_i = 12'h127; DecimalPoints_i = 3'b000; Load_i = 1'b1;
        step();
        Load_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if ({Digits_o, Segments_o} !== {3'b101, 8'hA4}) begin
            failures++;
            $display("FAIL mid_before: got dig=%b seg=%h want 101/a4", Digits_o, Segments_o);
        end
        // Scan now sits at count 2 of digit 1; pulse reset for one edge.
        Reset = 1'b0;
        step();
        checks++;
        if ({Digits_o, Segments_o, Frame_o} !== {3'b111, 8'hFF, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset: got dig=%b seg=%h frame=%b want 111/ff/0",
                     Digits_o, Segments_o, Frame_o);
        end
        Reset = 1'b1;
        n     = 0;
        for (int i = 0; i < 13; i++) begin
            step();
            checks++;
            if ({Digits_o, Segments_o} !== {3'b111, 8'hFF}) begin
                failures++;
                $display("FAIL mid_blank n=%0d: got dig=%b seg=%h want 111/ff",
                         n, Digits_o, Segments_o);
            end
            checks++;
            if (Frame_o !== (n == 13)) begin
                failures++;
                $display("FAIL mid_frame n=%0d: got %b want %b", n, Frame_o, (n == 13));
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        DecimalPoints_i = 3'b000;
        BCD_i = 12'h111; Load_i = 1'b1;
        step();
        BCD_i = 12'h222;
        step();
        checks++;
        if ({Digits_o, Segments_o} !== {3'b110, 8'hF9}) begin
            failures++;
            $display("FAIL b2b_111: got dig=%b seg=%h want 110/f9", Digits_o, Segments_o);
        end
        BCD_i = 12'h33F;
        step();
        checks++;
        if ({Digits_o, Segments_o} !== {3'b110, 8'hA4}) begin
            failures++;
            $display("FAIL b2b_222: got dig=%b seg=%h want 110/a4", Digits_o, Segments_o);
        end
        Load_i = 1'b0;
        step();
        checks++;
        if ({Digits_o, Segments_o} !== {3'b110, 8'hBF}) begin
            failures++;
            $display("FAIL b2b_dash: got dig=%b seg=%h want 110/bf", Digits_o, Segments_o);
        end
        step();
        checks++;
        if ({Digits_o, Segments_o} !== {3'b111, 8'hFF}) begin
            failures++;
            $display("FAIL b2b_blank: got dig=%b seg=%h want 111/ff", Digits_o, Segments_o);
        end
        step();
        checks++;
        if ({Digits_o, Segments_o} !== {3'b101, 8'hB0}) begin
            failures++;
            $display("FAIL b2b_digit1: got dig=%b seg=%h want 101/b0", Digits_o, Segments_o);
        end
    endtask

    initial begin
        Reset = 1'b0; Load_i = 1'b0; BCD_i = '0; DecimalPoints_i = '0;
        test_reset();
        test_scan_127();
        test_leading_zero();
        test_decimal_point();
        test_dash_reload();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_display_mux.md
BCD_DISPLAY_MUX -- requirements
Module: bcd_display_mux

Interface
REQ-001 The block SHALL have parameter DIGITS, default 3, giving the number of BCD digits and display positions.
REQ-002 The block SHALL have parameter DIGIT_TICKS, default 1000, giving the clocks per digit time slot.
REQ-003 The block SHALL have parameter BLANK_TICKS, default 50, giving the clocks at the start of each slot with all digits off (anti-ghosting).
REQ-004 The block SHALL have port Clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port Reset, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port Load_i, input, 1 bit: latch strobe, normally driven by the converter's Done_o.
REQ-007 The block SHALL have port BCD_i, input, DIGITS*4 bits: packed BCD value; digit 0 is bits [3:0].
REQ-008 The block SHALL have port DecimalPoints_i, input, DIGITS bits: decimal point enable per digit, latched with BCD_i.
REQ-009 The block SHALL have port Segments_o, output, 8 bits: {dp,g,f,e,d,c,b,a}, active-low.
REQ-010 The block SHALL have port Digits_o, output, DIGITS bits: digit enables, active-low, at most one low at a time.
REQ-011 The block SHALL have port Frame_o, output, 1 bit: one-clock pulse each time the scan wraps from digit DIGITS-1 to digit 0.

Function
REQ-012 On a rising edge with Load_i=1, the block SHALL latch BCD_i and DecimalPoints_i into internal registers and set the Valid flag; the scan SHALL NOT restart.
REQ-013 While Load_i is held high, the block SHALL re-latch on every edge.
REQ-014 The scan SHALL work as follows: the tick counter counts 0..DIGIT_TICKS-1; at DIGIT_TICKS-1 it wraps to 0 and the digit index advances DIGITS-1 -> 0 wrap.
REQ-015 All outputs SHALL be registered, reflecting the counter, index and latched data of the previous cycle (1-cycle latency).
REQ-016 When counter < BLANK_TICKS, or Valid=0, the block SHALL drive Digits_o all ones and Segments_o = 8'hFF.
REQ-017 Otherwise the block SHALL drive Digits_o[index]=0 with all other bits 1, and Segments_o = the glyph of the nibble at index, with dp low iff that digit's DecimalPoints bit is 1.
REQ-018 Glyphs SHALL use standard 7-segment patterns, for example 0=C0, 1=F9, 7=F8, 8=80, 9=90 (hex, dp off).
REQ-019 A nibble greater than 9 SHALL display a dash (g only, BF).
REQ-020 Frame_o SHALL be high for exactly one cycle, aligned with the first output cycle of digit 0's slot.
REQ-021 If Load_i arrives mid-slot, the new data SHALL appear on the outputs from the next cycle, within the same slot.
REQ-022 The parameter set SHALL satisfy BLANK_TICKS < DIGIT_TICKS, DIGITS >= 1 and DIGIT_TICKS >= 2; any other set is unsupported.

Reset
REQ-023 When Reset=0 at a rising edge, the block SHALL clear the counter, digit index, latched BCD, latched decimal points, Valid and Frame_o.
REQ-024 During reset and until the first load, outputs SHALL be Digits_o all ones and Segments_o = FF.
REQ-025 Reset asserted mid-slot SHALL take effect at that edge; after release the scan SHALL restart at digit 0, count 0, blanked until the next Load_i.

Configuration
REQ-026 With LEADING_ZERO_BLANK_EN defined, digit k (k>0) SHALL be blanked (Segments_o = FF, Digits_o[k] still low) iff, for every j >= k, nibble j = 0 and DecimalPoints bit j = 0.
REQ-027 Without LEADING_ZERO_BLANK_EN, every digit SHALL display its glyph, including leading zeros.
REQ-028 Digit 0 SHALL never be blanked by this feature in either configuration.

Verification (bench: DIGITS=3, DIGIT_TICKS=4, BLANK_TICKS=1)
REQ-029 Scenario: Reset low for 2 cycles, then high with no load -> Digits_o = 111 and Segments_o = FF indefinitely, with Frame_o pulses every 12 cycles.
REQ-030 Scenario: Load BCD 12'h127, DP 000 -> per 4-cycle slot, 1 blank cycle then 3 cycles of Digits_o 110/F8, 101/A4, 011/F9 in turn.
REQ-031 Scenario: Load 12'h007 with macro defined -> digit 2 and digit 1 slots show FF and digit 0 shows F8; without the macro -> C0, C0, F8.
REQ-032 Scenario: Load 12'h005, DP 010, macro defined -> digit 2 FF, digit 1 40 ("0."), digit 0 92.
REQ-033 Scenario: Load 12'h0A9 -> digit 1 shows BF, digit 0 shows 90; reload 12'h321 mid-slot -> the change is visible the next cycle and the scan phase is unchanged.
REQ-034 Scenario: Reset pulse at count 2 of digit 1 -> next output is blank, and Frame_o is observed 12 cycles after release.
